// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: per-frame pong sequencer.
// Moves paddles, resolves hits, steps the ball, scores goals.
module pong_game_ctrl #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int PAD_HW       = 25,
  parameter int PAD_HH       = 33,
  parameter int BALL_HW      = 10,
  parameter int BALL_HH      = 15,
  parameter int P1_XMAX      = 270,
  parameter int P2_XMIN      = 370,
  parameter int GOAL_YTOP    = 200,
  parameter int GOAL_YBOT    = 280,
  parameter int GOAL_DEPTH   = 4,
  parameter int WIN_SCORE    = 5,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_end,
  input  logic       start,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p1_left,
  input  logic       p1_right,
  input  logic       p2_up,
  input  logic       p2_down,
  input  logic       p2_left,
  input  logic       p2_right,
  input  logic [9:0] ball_x,
  input  logic [8:0] ball_y,
  input  logic       step_ack,
  output logic       step_req,
  output logic       ball_reload,
  output logic [1:0] ball_xdir,
  output logic [1:0] ball_ydir,
  output logic [9:0] p1_x,
  output logic [8:0] p1_y,
  output logic [9:0] p2_x,
  output logic [8:0] p2_y,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [1:0] winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_ATTRACT = 3'd0,
    ST_SERVE   = 3'd1,
    ST_PLAY    = 3'd2,
    ST_OVER    = 3'd3
  } state_t;

  typedef enum logic [2:0] {
    PH_IDLE, PH_MOVE, PH_HIT, PH_REQ, PH_CHK
  } phase_t;

  localparam int CW = $clog2(SERVE_FRAMES + 1);

  localparam logic [9:0]  P1_XLO = 10'(PAD_HW + 1);
  localparam logic [9:0]  P1_XHI = 10'(P1_XMAX);
  localparam logic [9:0]  P2_XLO = 10'(P2_XMIN);
  localparam logic [9:0]  P2_XHI = 10'(WIDTH - PAD_HW - 1);
  localparam logic [9:0]  Y_LO   = 10'(PAD_HH + 1);
  localparam logic [9:0]  Y_HI   = 10'(HEIGHT - PAD_HH - 1);
  localparam logic [10:0] OV_X   = 11'(BALL_HW + PAD_HW);
  localparam logic [10:0] OV_Y   = 11'(BALL_HH + PAD_HH);
  localparam logic [10:0] SIDE_X = 11'(PAD_HW);
  localparam logic [9:0]  GL_X   = 10'(BALL_HW + GOAL_DEPTH);
  localparam logic [9:0]  GR_X   = 10'(WIDTH - 1 - BALL_HW - GOAL_DEPTH);
  localparam logic [8:0]  G_TOP  = 9'(GOAL_YTOP);
  localparam logic [8:0]  G_BOT  = 9'(GOAL_YBOT);
  localparam logic [3:0]  WIN    = 4'(WIN_SCORE);
  localparam logic [CW-1:0] SV_LAST = CW'(SERVE_FRAMES - 1);
  localparam logic [1:0]  DIR_P  = 2'b01;
  localparam logic [1:0]  DIR_N  = 2'b11;

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        fe_q, st_q;
  logic        step_req_q, step_req_d;
  logic        reload_q, reload_d;
  logic [1:0]  xdir_q, xdir_d, ydir_q, ydir_d;
  logic [9:0]  p1x_q, p1x_d, p2x_q, p2x_d;
  logic [8:0]  p1y_q, p1y_d, p2y_q, p2y_d;
  logic [9:0]  bx_q, bx_d;
  logic [8:0]  by_q, by_d;
  logic [3:0]  s1_q, s1_d, s2_q, s2_d;
  logic [1:0]  win_q, win_d;

  logic        tick, start_edge;
  logic [9:0]  p1x_mv, p2x_mv;
  logic [8:0]  p1y_mv, p2y_mv;
  logic [10:0] bx11, by11, d1x, d1y, d2x, d2y;
  logic        ov1, ov2;

  function automatic logic [9:0] mv(
    input logic [9:0] v,
    input logic       dec,
    input logic       inc,
    input logic [9:0] lo,
    input logic [9:0] hi
  );
    logic [9:0] n;
    n = v;
    if (dec && !inc && v > lo) n = v - 10'd1;
    else if (inc && !dec && v < hi) n = v + 10'd1;
    return n;
  endfunction

  function automatic logic [10:0] absd(
    input logic [10:0] a,
    input logic [10:0] b
  );
    return (a > b) ? a - b : b - a;
  endfunction

  assign tick       = frame_end & ~fe_q;
  assign start_edge = start & ~st_q;

  // Candidate paddle positions and ball/paddle overlap terms
  always_comb begin
    p1x_mv = mv(p1x_q, p1_left, p1_right, P1_XLO, P1_XHI);
    p2x_mv = mv(p2x_q, p2_left, p2_right, P2_XLO, P2_XHI);
    p1y_mv = 9'(mv({1'b0, p1y_q}, p1_up, p1_down, Y_LO, Y_HI));
    p2y_mv = 9'(mv({1'b0, p2y_q}, p2_up, p2_down, Y_LO, Y_HI));
    bx11 = {1'b0, bx_q};
    by11 = {2'b0, by_q};
    d1x  = absd(bx11, {1'b0, p1x_q});
    d1y  = absd(by11, {2'b0, p1y_q});
    d2x  = absd(bx11, {1'b0, p2x_q});
    d2y  = absd(by11, {2'b0, p2y_q});
    ov1  = (d1x < OV_X) && (d1y < OV_Y);
    ov2  = (d2x < OV_X) && (d2y < OV_Y);
  end

  // Next-state logic for the game and the per-frame sub-sequence
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    step_req_d = step_req_q;
    reload_d   = reload_q;
    xdir_d     = xdir_q;
    ydir_d     = ydir_q;
    p1x_d      = p1x_q;
    p1y_d      = p1y_q;
    p2x_d      = p2x_q;
    p2y_d      = p2y_q;
    bx_d       = bx_q;
    by_d       = by_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    win_d      = win_q;
    unique case (state_q)
      ST_ATTRACT: begin
        reload_d = 1'b1;
        if (start_edge) begin
          s1_d    = '0;
          s2_d    = '0;
          win_d   = '0;
          xdir_d  = DIR_P;
          ydir_d  = DIR_P;
          cnt_d   = '0;
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        reload_d = 1'b1;
        if (tick) begin
          p1x_d = p1x_mv;
          p1y_d = p1y_mv;
          p2x_d = p2x_mv;
          p2y_d = p2y_mv;
          if (cnt_q == SV_LAST) begin
            state_d  = ST_PLAY;
            phase_d  = PH_IDLE;
            reload_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_PLAY: begin
        unique case (phase_q)
          PH_IDLE: if (tick) phase_d = PH_MOVE;
          PH_MOVE: begin
            p1x_d   = p1x_mv;
            p1y_d   = p1y_mv;
            p2x_d   = p2x_mv;
            p2y_d   = p2y_mv;
            phase_d = PH_HIT;
          end
          PH_HIT: begin
            // Set factors away from the paddle; P1 wins ties
            if (ov1) begin
              if (d1x >= SIDE_X)
                xdir_d = (bx11 > {1'b0, p1x_q}) ? DIR_P : DIR_N;
              else
                ydir_d = (by11 > {2'b0, p1y_q}) ? DIR_P : DIR_N;
            end else if (ov2) begin
              if (d2x >= SIDE_X)
                xdir_d = (bx11 > {1'b0, p2x_q}) ? DIR_P : DIR_N;
              else
                ydir_d = (by11 > {2'b0, p2y_q}) ? DIR_P : DIR_N;
            end
            step_req_d = 1'b1;
            phase_d    = PH_REQ;
          end
          PH_REQ: begin
            if (step_ack) begin
              bx_d       = ball_x;
              by_d       = ball_y;
              step_req_d = 1'b0;
              phase_d    = PH_CHK;
            end
          end
          PH_CHK: begin
            phase_d = PH_IDLE;
            if (by_q > G_TOP && by_q < G_BOT) begin
              if (bx_q <= GL_X) begin
                s2_d     = s2_q + 4'd1;
                xdir_d   = DIR_N;
                ydir_d   = DIR_P;
                reload_d = 1'b1;
                cnt_d    = '0;
                state_d  = ST_SERVE;
                if (s2_d >= WIN) begin
                  win_d   = 2'd2;
                  state_d = ST_OVER;
                end
              end else if (bx_q >= GR_X) begin
                s1_d     = s1_q + 4'd1;
                xdir_d   = DIR_P;
                ydir_d   = DIR_P;
                reload_d = 1'b1;
                cnt_d    = '0;
                state_d  = ST_SERVE;
                if (s1_d >= WIN) begin
                  win_d   = 2'd1;
                  state_d = ST_OVER;
                end
              end
            end
          end
          default: phase_d = PH_IDLE;
        endcase
      end
      ST_OVER: begin
        reload_d = 1'b1;
        if (start_edge) begin
          s1_d    = '0;
          s2_d    = '0;
          win_d   = '0;
          cnt_d   = '0;
          state_d = ST_SERVE;
        end
      end
      default: begin
        state_d  = ST_ATTRACT;
        reload_d = 1'b1;
      end
    endcase
  end

  // State registers; edge detectors start high so no tick on exit from reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_ATTRACT;
      phase_q    <= PH_IDLE;
      cnt_q      <= '0;
      fe_q       <= 1'b1;
      st_q       <= 1'b1;
      step_req_q <= 1'b0;
      reload_q   <= 1'b1;
      xdir_q     <= DIR_P;
      ydir_q     <= DIR_P;
      p1x_q      <= 10'd80;
      p1y_q      <= 9'd240;
      p2x_q      <= 10'd560;
      p2y_q      <= 9'd240;
      bx_q       <= '0;
      by_q       <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      win_q      <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      fe_q       <= frame_end;
      st_q       <= start;
      step_req_q <= step_req_d;
      reload_q   <= reload_d;
      xdir_q     <= xdir_d;
      ydir_q     <= ydir_d;
      p1x_q      <= p1x_d;
      p1y_q      <= p1y_d;
      p2x_q      <= p2x_d;
      p2y_q      <= p2y_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      win_q      <= win_d;
    end
  end

  assign step_req    = step_req_q;
  assign ball_reload = reload_q;
  assign ball_xdir   = xdir_q;
  assign ball_ydir   = ydir_q;
  assign p1_x        = p1x_q;
  assign p1_y        = p1y_q;
  assign p2_x        = p2x_q;
  assign p2_y        = p2y_q;
  assign score_p1    = s1_q;
  assign score_p2    = s2_q;
  assign winner      = win_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: random frames against a game-rules model.
// Covers serve, handshake, clamping, hits, goals, win, reset.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_end = 1'b0, start = 1'b0;
  logic       p1_up = 0, p1_down = 0, p1_left = 0, p1_right = 0;
  logic       p2_up = 0, p2_down = 0, p2_left = 0, p2_right = 0;
  logic [9:0] ball_x = '0;
  logic [8:0] ball_y = '0;
  logic       step_ack = 1'b0;
  logic       step_req, ball_reload;
  logic [1:0] ball_xdir, ball_ydir, winner;
  logic [9:0] p1_x, p2_x;
  logic [8:0] p1_y, p2_y;
  logic [3:0] score_p1, score_p2;
  logic [2:0] state;

  pong_game_ctrl dut (
    .clk(clk), .reset(reset), .frame_end(frame_end), .start(start),
    .p1_up(p1_up), .p1_down(p1_down),
    .p1_left(p1_left), .p1_right(p1_right),
    .p2_up(p2_up), .p2_down(p2_down),
    .p2_left(p2_left), .p2_right(p2_right),
    .ball_x(ball_x), .ball_y(ball_y), .step_ack(step_ack),
    .step_req(step_req), .ball_reload(ball_reload),
    .ball_xdir(ball_xdir), .ball_ydir(ball_ydir),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .score_p1(score_p1), .score_p2(score_p2),
    .winner(winner), .state(state)
  );

  always #20 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // game-level model: 0 attract, 1 serve, 2 play, 3 over
  int m_st, m_cnt, m_p1x, m_p1y, m_p2x, m_p2y;
  int m_s1, m_s2, m_win, m_xd, m_yd, m_bx, m_by;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int mv(input int v, input bit dec, input bit inc,
                            input int lo, input int hi);
    int n;
    n = v + (inc ? 1 : 0) - (dec ? 1 : 0);
    if (n < lo) n = lo;
    if (n > hi) n = hi;
    return n;
  endfunction

  task automatic m_reset();
    m_st = 0; m_cnt = 0;
    m_p1x = 80; m_p1y = 240; m_p2x = 560; m_p2y = 240;
    m_s1 = 0; m_s2 = 0; m_win = 0; m_xd = 1; m_yd = 1;
    m_bx = 0; m_by = 0;
  endtask

  task automatic m_away(input int px, input int py);
    if (iabs(m_bx - px) >= 25) m_xd = (m_bx > px) ? 1 : -1;
    else m_yd = (m_by > py) ? 1 : -1;
  endtask

  task automatic m_tick(input logic [7:0] b);
    if (m_st == 1 || m_st == 2) begin
      m_p1y = mv(m_p1y, b[7], b[6], 34, 446);
      m_p1x = mv(m_p1x, b[5], b[4], 26, 270);
      m_p2y = mv(m_p2y, b[3], b[2], 34, 446);
      m_p2x = mv(m_p2x, b[1], b[0], 370, 614);
    end
    if (m_st == 1) begin
      m_cnt++;
      if (m_cnt == 60) m_st = 2;
    end else if (m_st == 2) begin
      if (iabs(m_bx - m_p1x) < 35 && iabs(m_by - m_p1y) < 48)
        m_away(m_p1x, m_p1y);
      else if (iabs(m_bx - m_p2x) < 35 && iabs(m_by - m_p2y) < 48)
        m_away(m_p2x, m_p2y);
    end
  endtask

  task automatic m_goal();
    if (m_by > 200 && m_by < 280) begin
      if (m_bx <= 14) begin
        m_s2++; m_xd = -1; m_yd = 1; m_st = 1; m_cnt = 0;
        if (m_s2 >= 5) begin m_st = 3; m_win = 2; end
      end else if (m_bx >= 625) begin
        m_s1++; m_xd = 1; m_yd = 1; m_st = 1; m_cnt = 0;
        if (m_s1 >= 5) begin m_st = 3; m_win = 1; end
      end
    end
  endtask

  task automatic check_all();
    chk("state", state, m_st);
    chk("p1x", p1_x, m_p1x);
    chk("p1y", p1_y, m_p1y);
    chk("p2x", p2_x, m_p2x);
    chk("p2y", p2_y, m_p2y);
    chk("s1", score_p1, m_s1);
    chk("s2", score_p2, m_s2);
    chk("win", winner, m_win);
    chk("xdir", int'($signed(ball_xdir)), m_xd);
    chk("ydir", int'($signed(ball_ydir)), m_yd);
    chk("reload", ball_reload, (m_st != 2) ? 1 : 0);
  endtask

  task automatic frame(input logic [7:0] b, input int bx, input int by,
                       input int dly, input bit extra);
    int was;
    bit got;
    was = m_st;
    @(negedge clk);
    {p1_up, p1_down, p1_left, p1_right,
     p2_up, p2_down, p2_left, p2_right} = b;
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    m_tick(b);
    if (was == 2) begin
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        if (step_req) got = 1'b1;
        else @(negedge clk);
      end
      chk("req_up", got, 1);
      if (got) begin
        for (int i = 0; i < dly; i++) begin
          if (extra && i == 1) frame_end = 1'b1;
          if (extra && i == 2) frame_end = 1'b0;
          @(negedge clk);
        end
        frame_end = 1'b0;
        chk("req_hold", step_req, 1);
        ball_x = 10'(bx);
        ball_y = 9'(by);
        step_ack = 1'b1;
        @(negedge clk);
        step_ack = 1'b0;
        chk("req_drop", step_req, 0);
        m_bx = bx;
        m_by = by;
        m_goal();
      end
    end
    repeat (4) @(negedge clk);
    chk("no_req", step_req, 0);
    check_all();
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2) @(negedge clk);
    if (m_st == 0) begin
      m_s1 = 0; m_s2 = 0; m_win = 0; m_xd = 1; m_yd = 1;
      m_st = 1; m_cnt = 0;
    end else if (m_st == 3) begin
      m_s1 = 0; m_s2 = 0; m_win = 0; m_st = 1; m_cnt = 0;
    end
    check_all();
  endtask

  task automatic serve(input int n, input bit rnd);
    for (int i = 0; i < n; i++)
      frame(rnd ? 8'($urandom) : 8'h00, 320, 100, 1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_reset();
    @(negedge clk);
  endtask

  initial begin
    int sx;
    bit got;
    m_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_req", step_req, 0);
    chk("rst_reload", ball_reload, 1);
    chk("rst_p1x", p1_x, 80);
    chk("rst_p2x", p2_x, 560);
    check_all();

    // attract: ticks with buttons leave everything frozen
    for (int i = 0; i < 3; i++) frame(8'hFF, 320, 240, 1, 1'b0);
    chk("attract_p1y", p1_y, 240);

    pulse_start();
    chk("serve_state", state, 1);
    serve(10, 1'b1);
    pulse_start();
    serve(50, 1'b1);
    chk("serve_to_play", state, 2);

    // delayed ack with a stray tick during the wait
    frame(8'h00, 320, 240, 5, 1'b1);
    for (int i = 0; i < 40; i++) begin
      int d;
      d = $urandom_range(0, 6);
      frame(8'($urandom), $urandom_range(100, 540),
            $urandom_range(20, 460), d, (d >= 3) && $urandom_range(0, 1));
    end

    // p1 up held with left+right together
    sx = m_p1x;
    for (int i = 0; i < 300; i++)
      frame(8'b1011_0000, 320, 100, $urandom_range(0, 3), 1'b0);
    chk("p1y_clamp", p1_y, 34);
    chk("p1x_hold", p1_x, sx);

    // fresh game with paddles at home for collision checks
    do_reset();
    pulse_start();
    serve(60, 1'b0);
    frame(8'h00, 50, 240, 1, 1'b0);
    frame(8'h00, 110, 240, 2, 1'b0);
    chk("hit_left", int'($signed(ball_xdir)), -1);
    frame(8'h00, 110, 240, 1, 1'b0);
    chk("hit_right1", int'($signed(ball_xdir)), 1);
    frame(8'h00, 110, 240, 3, 1'b0);
    chk("hit_right2", int'($signed(ball_xdir)), 1);
    frame(8'h00, 80, 200, 0, 1'b0);
    chk("hit_right3", int'($signed(ball_xdir)), 1);
    frame(8'h00, 320, 240, 1, 1'b0);
    chk("hit_top", int'($signed(ball_ydir)), -1);
    frame(8'h00, 14, 100, 1, 1'b0);
    chk("wall_noscore", score_p2, 0);
    frame(8'h00, 14, 240, 2, 1'b0);
    chk("goal_p2", score_p2, 1);
    chk("goal_state", state, 1);
    chk("goal_xdir", int'($signed(ball_xdir)), -1);

    // five P1 goals end the game
    for (int g = 0; g < 5; g++) begin
      serve(60, 1'b1);
      frame(8'h00, 625, 240, $urandom_range(0, 4), 1'b0);
    end
    chk("win_s1", score_p1, 5);
    chk("win_who", winner, 1);
    chk("win_state", state, 3);
    frame(8'hFF, 320, 240, 1, 1'b0);
    pulse_start();
    chk("restart_s1", score_p1, 0);
    chk("restart_state", state, 1);

    // reset in the middle of a handshake
    serve(60, 1'b0);
    @(negedge clk) frame_end = 1'b1;
    @(negedge clk) frame_end = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (step_req) got = 1'b1;
      else @(negedge clk);
    end
    chk("mid_req_up", got, 1);
    #5 reset = 1'b1;
    #1 chk("rst_async", step_req, 0);
    @(negedge clk) reset = 1'b0;
    ball_x = 10'd14;
    ball_y = 9'd240;
    step_ack = 1'b1;
    @(negedge clk) step_ack = 1'b0;
    repeat (3) @(negedge clk);
    m_reset();
    chk("late_ack", step_req, 0);
    check_all();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
